// File: rtl/vga_scanout.sv
// vga_scanout: 160x120x3 framebuffer scanout with 640x480@60 VGA timing and 4x4 pixel replication
// Ports: CLOCK_50/resetn clock and async active-low reset; rd_addr/rd_data framebuffer read port
// (sync RAM, one cycle latency); VGA_* pins; frame_start pulse at the frame wrap; vblank status.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        frame_start,
    output logic        vblank
);
    localparam logic [9:0] H_VIS_W = 10'(H_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_W = 10'(V_VIS);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic        phase_q, phase_d;
    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic [14:0] rd_addr_q, rd_addr_d;
    logic        visible_q, visible_d, hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic        blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        h_wrap, v_wrap, visible;
    logic [6:0]  row;
    logic [7:0]  col;

    // phase_q doubles as the pixel enable: every stage advances on the edge ending a phase=1 cycle
    always_comb begin
        h_wrap    = hcount_q == H_LAST;
        v_wrap    = vcount_q == V_LAST;
        visible   = (hcount_q < H_VIS_W) && (vcount_q < V_VIS_W);
        row       = vcount_q[8:2];
        col       = hcount_q[9:2];
        phase_d   = ~phase_q;
        hcount_d  = !phase_q ? hcount_q : h_wrap ? 10'd0 : hcount_q + 10'd1;
        vcount_d  = !(phase_q && h_wrap) ? vcount_q : v_wrap ? 10'd0 : vcount_q + 10'd1;
        // row*160 built as row*128 + row*32
        rd_addr_d = (phase_q && visible) ? {1'b0, row, 7'd0} + {3'd0, row, 5'd0} + {7'd0, col} : rd_addr_q;
        visible_d = phase_q ? visible : visible_q;
        hs_raw_d  = phase_q ? !(hcount_q >= HS_BEG && hcount_q < HS_END) : hs_raw_q;
        vs_raw_d  = phase_q ? !(vcount_q >= VS_BEG && vcount_q < VS_END) : vs_raw_q;
        blank_d   = phase_q ? visible_q : blank_q;
        hs_d      = phase_q ? hs_raw_q : hs_q;
        vs_d      = phase_q ? vs_raw_q : vs_q;
        rgb_d     = phase_q ? (visible_q ? rd_data : 3'd0) : rgb_q;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            phase_q   <= 1'b0;
            hcount_q  <= 10'd0;
            vcount_q  <= 10'd0;
            rd_addr_q <= 15'd0;
            visible_q <= 1'b0;
            hs_raw_q  <= 1'b1;
            vs_raw_q  <= 1'b1;
            blank_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= 3'd0;
        end else begin
            phase_q   <= phase_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            rd_addr_q <= rd_addr_d;
            visible_q <= visible_d;
            hs_raw_q  <= hs_raw_d;
            vs_raw_q  <= vs_raw_d;
            blank_q   <= blank_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_CLK     = phase_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = {10{rgb_q[2]}};
    assign VGA_G       = {10{rgb_q[1]}};
    assign VGA_B       = {10{rgb_q[0]}};
    assign frame_start = phase_q && h_wrap && v_wrap;
    assign vblank      = vcount_q >= V_VIS_W;
endmodule
